// File: rtl/etx_arbiter_if.sv
// Transmit-arbiter bundle: three upstream request channels, remote/local
// pushback and the registered beat presented to etx_io.
interface etx_arbiter_if #(
  parameter int PW = 104
);
  logic          txrr_access;
  logic [PW-1:0] txrr_packet;
  logic          txrr_wait;
  logic          txrd_access;
  logic [PW-1:0] txrd_packet;
  logic          txrd_wait;
  logic          txwr_access;
  logic [PW-1:0] txwr_packet;
  logic          txwr_wait;
  logic          tx_io_wait;
  logic          tx_wr_wait;
  logic          tx_rd_wait;
  logic          tx_access;
  logic [PW-1:0] tx_packet;
  logic          tx_burst;

  modport slave (
    input  txrr_access, txrr_packet, txrd_access, txrd_packet,
           txwr_access, txwr_packet, tx_io_wait, tx_wr_wait, tx_rd_wait,
    output txrr_wait, txrd_wait, txwr_wait, tx_access, tx_packet, tx_burst
  );

  modport master (
    output txrr_access, txrr_packet, txrd_access, txrd_packet,
           txwr_access, txwr_packet, tx_io_wait, tx_wr_wait, tx_rd_wait,
    input  txrr_wait, txrd_wait, txwr_wait, tx_access, tx_packet, tx_burst
  );
endinterface

// File: rtl/etx_arbiter.sv
// Round-robin sequencer of the txrr/txrd/txwr channels onto the shared etx_io
// datapath, with a bounded lock for sequential doubleword write bursts.
module etx_arbiter #(
  parameter int PW        = 104,
  parameter int BURST_MAX = 16
) (
  input logic          clk,
  input logic          reset,
  etx_arbiter_if.slave io
);

  localparam int CW = $clog2(BURST_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

  // Last-granted channel; search starts at the channel after it.
  localparam logic [1:0] PTR_RR = 2'd0;
  localparam logic [1:0] PTR_RD = 2'd1;
  localparam logic [1:0] PTR_WR = 2'd2;

  logic [1:0]    ptr;
  logic [CW-1:0] count;
  logic          rr_el, rd_el, wr_el;
  logic          cmp, lock;
  logic [2:0]    grant;          // {wr, rd, rr}
  logic [PW-1:0] sel_packet;
  logic [31:0]   next_dst;

  assign rr_el = ~io.tx_io_wait & io.txrr_access & ~io.tx_wr_wait;
  assign rd_el = ~io.tx_io_wait & io.txrd_access & ~io.tx_rd_wait;
  assign wr_el = ~io.tx_io_wait & io.txwr_access & ~io.tx_wr_wait;

  // tx_access stays high only across back-to-back grants (stalls hold it),
  // so it doubles as the adjacency qualifier for the previous beat.
  assign next_dst = io.tx_packet[39:8] + 32'd8;
  assign cmp = io.tx_access & io.tx_packet[0] & (io.tx_packet[2:1] == 2'b11) &
               io.txwr_packet[0] & (io.txwr_packet[2:1] == 2'b11) &
               (io.txwr_packet[7:3] == io.tx_packet[7:3]) &
               (io.txwr_packet[39:8] == next_dst);
  assign lock = cmp & (count < CNT_LAST);

  always_comb begin
    grant = '0;
    if (wr_el & lock) begin
      grant = 3'b100;
    end else begin
      case (ptr)
        PTR_RR: begin
          if (rd_el)      grant = 3'b010;
          else if (wr_el) grant = 3'b100;
          else if (rr_el) grant = 3'b001;
        end
        PTR_RD: begin
          if (wr_el)      grant = 3'b100;
          else if (rr_el) grant = 3'b001;
          else if (rd_el) grant = 3'b010;
        end
        default: begin
          if (rr_el)      grant = 3'b001;
          else if (rd_el) grant = 3'b010;
          else if (wr_el) grant = 3'b100;
        end
      endcase
    end
  end

  always_comb begin
    sel_packet = io.txrr_packet;
    if (grant[2])      sel_packet = io.txwr_packet;
    else if (grant[1]) sel_packet = io.txrd_packet;
  end

  assign io.txrr_wait = reset | io.tx_io_wait | ~grant[0];
  assign io.txrd_wait = reset | io.tx_io_wait | ~grant[1];
  assign io.txwr_wait = reset | io.tx_io_wait | ~grant[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io.tx_access <= 1'b0;
      io.tx_packet <= '0;
      io.tx_burst  <= 1'b0;
      ptr          <= PTR_WR;
      count        <= '0;
    end else if (!io.tx_io_wait) begin
      io.tx_access <= |grant;
      io.tx_burst  <= grant[2] & lock;
      // A write arriving at the count limit is issued as a fresh beat,
      // which both breaks the burst and restarts the count.
      count        <= (grant[2] & lock) ? count + 1'b1 : '0;
      if (|grant) begin
        io.tx_packet <= sel_packet;
        ptr <= grant[2] ? PTR_WR : (grant[1] ? PTR_RD : PTR_RR);
      end
    end
  end

endmodule

// File: tb/tb_etx_arbiter.sv
// Randomized scoreboard bench for etx_arbiter against a channel-level model.
module tb_etx_arbiter;
  localparam int PW = 104;
  localparam int BM = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  etx_arbiter_if #(.PW(PW)) io();
  etx_arbiter #(.PW(PW), .BURST_MAX(BM)) dut (.clk(clk), .reset(reset), .io(io));

  typedef struct packed {
    logic          v;
    logic [PW-1:0] p;
    logic          b;
  } beat_t;

  beat_t sbq[$];
  int checks = 0;
  int errors = 0;

  // stimulus state (channel 0=rr, 1=rd, 2=wr)
  bit            acc[3];
  logic [PW-1:0] pkt[3];
  int            xfer;
  int            p_req[3];
  bit            wr_seq;
  int            wr_step;
  logic [1:0]    wr_dm;
  logic [31:0]   wr_addr;
  int            wr_left;
  int            iow_pct, wrw_pct, rdw_pct;
  bit            rst_req;

  // reference model state
  int            last;
  int            run;
  logic          mv;
  logic [PW-1:0] mp;
  logic          mb;

  logic iow_s, rst_s;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input int c);
    logic        wbit;
    logic [1:0]  dm;
    logic [4:0]  ctrl;
    logic [31:0] dst, data, src;
    wbit = (c != 1);
    dm   = 2'($urandom);
    ctrl = 5'($urandom);
    dst  = $urandom;
    data = $urandom;
    src  = $urandom;
    if (c == 2 && wr_seq) begin
      dm      = wr_dm;
      ctrl    = 5'd0;
      dst     = wr_addr;
      wr_addr = wr_addr + 32'(wr_step);
    end
    return {src, data, dst, ctrl, dm, wbit};
  endfunction

  task automatic set_phase(input int r0, input int r1, input int r2, input bit seq,
                           input int step, input logic [1:0] dm, input int wlim,
                           input int iw, input int ww, input int rw);
    p_req[0] = r0; p_req[1] = r1; p_req[2] = r2;
    wr_seq = seq; wr_step = step; wr_dm = dm; wr_addr = 32'h1000; wr_left = wlim;
    iow_pct = iw; wrw_pct = ww; rdw_pct = rw;
  endtask

  task automatic drive();
    for (int c = 0; c < 3; c++) begin
      if (!acc[c] || xfer == c) begin
        acc[c] = ($urandom_range(99, 0) < p_req[c]);
        if (c == 2 && wr_left <= 0) acc[c] = 1'b0;
        if (acc[c]) begin
          pkt[c] = mk_pkt(c);
          if (c == 2) wr_left--;
        end
      end
    end
    reset          = rst_req;
    io.tx_io_wait  = ($urandom_range(99, 0) < iow_pct);
    io.tx_wr_wait  = ($urandom_range(99, 0) < wrw_pct);
    io.tx_rd_wait  = ($urandom_range(99, 0) < rdw_pct);
    io.txrr_access = acc[0]; io.txrr_packet = pkt[0];
    io.txrd_access = acc[1]; io.txrd_packet = pkt[1];
    io.txwr_access = acc[2]; io.txwr_packet = pkt[2];
  endtask

  task automatic model_step();
    bit   el[3];
    bit   chain, lock, found, iow;
    int   g, c;
    logic [2:0] exp_w;
    xfer = -1;
    if (reset) begin
      chk("reset_waits", {io.txwr_wait, io.txrd_wait, io.txrr_wait}, 3'b111);
      chk("reset_tx_access", io.tx_access, 1'b0);
      chk("reset_tx_packet", io.tx_packet, '0);
      chk("reset_tx_burst", io.tx_burst, 1'b0);
      last = 2; run = 0; mv = 1'b0; mp = '0; mb = 1'b0;
      return;
    end
    iow   = io.tx_io_wait;
    el[0] = !iow && acc[0] && !io.tx_wr_wait;
    el[1] = !iow && acc[1] && !io.tx_rd_wait;
    el[2] = !iow && acc[2] && !io.tx_wr_wait;
    // a write continues the previous beat as the next sequential doubleword
    chain = mv && mp[0] && (mp[2:1] == 2'b11) && pkt[2][0] && (pkt[2][2:1] == 2'b11) &&
            (pkt[2][7:3] == mp[7:3]) && (pkt[2][39:8] == mp[39:8] + 32'd8);
    lock  = el[2] && chain && (run < BM - 1);
    g = -1;
    if (lock) g = 2;
    else begin
      found = 1'b0;
      for (int i = 1; i <= 3; i++) begin
        c = (last + i) % 3;
        if (!found && el[c]) begin g = c; found = 1'b1; end
      end
    end
    exp_w = {iow || g != 2, iow || g != 1, iow || g != 0};
    chk("waits", {io.txwr_wait, io.txrd_wait, io.txrr_wait}, exp_w);
    if (iow) begin
      chk("stall_tx_access", io.tx_access, mv);
      chk("stall_tx_packet", io.tx_packet, mp);
      chk("stall_tx_burst", io.tx_burst, mb);
    end else begin
      mb  = lock;
      run = lock ? run + 1 : 0;
      mv  = (g >= 0);
      if (g >= 0) begin
        mp   = pkt[g];
        last = g;
      end
      sbq.push_back('{v: mv, p: mp, b: mb});
      xfer = g;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2 drive();
      #2 model_step();
    end
  endtask

  // monitor: every non-stalled, non-reset edge presents a new output register
  initial begin
    beat_t e;
    forever begin
      @(posedge clk);
      iow_s = io.tx_io_wait;
      rst_s = reset;
      #1;
      if (!rst_s && !iow_s) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: got update with empty queue, required queued beat");
        end else begin
          e = sbq.pop_front();
          chk("tx_access", io.tx_access, e.v);
          chk("tx_packet", io.tx_packet, e.p);
          chk("tx_burst", io.tx_burst, e.b);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    rst_req = 1'b1;
    xfer = -1;
    for (int c = 0; c < 3; c++) begin acc[c] = 1'b0; pkt[c] = '0; end
    io.tx_io_wait = 1'b0; io.tx_wr_wait = 1'b0; io.tx_rd_wait = 1'b0;
    io.txrr_access = 1'b0; io.txrd_access = 1'b0; io.txwr_access = 1'b0;
    io.txrr_packet = '0; io.txrd_packet = '0; io.txwr_packet = '0;
    last = 2; run = 0; mv = 1'b0; mp = '0; mb = 1'b0;

    set_phase(100, 100, 100, 1'b0, 8, 2'b11, 1000000, 0, 0, 0);
    run_cycles(3);
    rst_req = 1'b0;
    run_cycles(30);                                            // strict rotation
    set_phase(0, 0, 0, 1'b0, 8, 2'b11, 0, 0, 0, 0);       run_cycles(4);
    set_phase(0, 0, 100, 1'b1, 8, 2'b11, 20, 0, 0, 0);    run_cycles(26);
    set_phase(0, 0, 0, 1'b0, 8, 2'b11, 0, 0, 0, 0);       run_cycles(4);
    set_phase(0, 100, 100, 1'b1, 8, 2'b11, 20, 0, 0, 0);  run_cycles(32);
    set_phase(0, 0, 0, 1'b0, 8, 2'b11, 0, 0, 0, 0);       run_cycles(4);
    set_phase(0, 0, 100, 1'b1, 8, 2'b11, 20, 0, 0, 0);    run_cycles(6);
    iow_pct = 100;                                        run_cycles(3);
    iow_pct = 0;                                          run_cycles(14);
    set_phase(100, 100, 100, 1'b0, 8, 2'b11, 1000000, 0, 100, 0); run_cycles(15);
    set_phase(0, 0, 0, 1'b0, 8, 2'b11, 0, 0, 0, 0);       run_cycles(4);
    set_phase(100, 100, 100, 1'b1, 4, 2'b11, 1000000, 0, 0, 0); run_cycles(20);
    set_phase(100, 100, 100, 1'b1, 8, 2'b10, 1000000, 0, 0, 0); run_cycles(20);
    set_phase(60, 60, 90, 1'b1, 8, 2'b11, 1000000, 15, 10, 10); run_cycles(70);
    rst_req = 1'b1;                                       run_cycles(2);
    rst_req = 1'b0;                                       run_cycles(80);
    set_phase(0, 0, 0, 1'b0, 8, 2'b11, 0, 0, 0, 0);       run_cycles(8);

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
